// File: rtl/cl_reg_access_arbiter.sv
// Round-robin arbiter that shares one single-beat register-access port among
// NREQ requesters. One transaction is outstanding at a time; a completion
// timeout guarantees that a hung target still produces a response.
module cl_reg_access_arbiter #(
  parameter int unsigned NREQ           = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic                 clk_main_a0,
  input  logic                 rst_main_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_we,
  input  logic [32*NREQ-1:0]   req_addr,
  input  logic [32*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic                 reg_valid,
  output logic                 reg_we,
  output logic [31:0]          reg_addr,
  output logic [31:0]          reg_wdata,
  input  logic                 reg_ready,
  input  logic [31:0]          reg_rdata,
  output logic [15:0]          timeout_count
);

  localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // A zero TIMEOUT_CYCLES disables the timeout; keep the counter at least 1 bit wide.
  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   last_gnt_q, last_gnt_d;
  logic [GW-1:0]   gnt_q, gnt_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [15:0]     tcount_q, tcount_d;

  logic            any_req;
  logic [GW-1:0]   gnt_idx;
  logic [31:0]     scan_pos;
  logic            timeout_hit;

  // Round-robin pick: first requester at or after last_gnt+1, wrapping at NREQ.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default first,
    //       so no path leaves it unassigned and no latch is inferred.
    any_req  = 1'b0;
    gnt_idx  = '0;
    scan_pos = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      scan_pos = 32'(last_gnt_q) + 32'(k);
      if (scan_pos >= NREQ) begin
        scan_pos = scan_pos - NREQ;
      end
      if (!any_req && req_valid[scan_pos[GW-1:0]]) begin
        any_req = 1'b1;
        gnt_idx = scan_pos[GW-1:0];
      end
    end
  end

  // Timeout fires on the ISSUE cycle that would make TIMEOUT_CYCLES cycles spent waiting.
  always_comb begin
    timeout_hit = (TIMEOUT_CYCLES != 0) && ((32'(cnt_q) + 32'd1) >= TIMEOUT_CYCLES);
  end

  // State register and captured transaction/response fields.
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      state_q    <= S_IDLE;
      last_gnt_q <= GW'(NREQ - 1);
      gnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      tcount_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values from
      //       before this edge, independent of statement order.
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      tcount_q   <= tcount_d;
    end
  end

  // Next-state logic: grant in IDLE, wait for completion or timeout in ISSUE, retire in RESP.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    tcount_d   = tcount_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_ISSUE;
          gnt_d   = gnt_idx;
          we_d    = req_we[gnt_idx];
          addr_d  = req_addr[{gnt_idx, 5'd0} +: 32];
          wdata_d = req_wdata[{gnt_idx, 5'd0} +: 32];
          cnt_d   = '0;
        end
      end
      S_ISSUE: begin
        cnt_d = cnt_q + CW'(1);
        // A completion in the timeout cycle wins over the timeout.
        if (reg_ready) begin
          state_d = S_RESP;
          rdata_d = we_q ? 32'd0 : reg_rdata;
          err_d   = 1'b0;
        end else if (timeout_hit) begin
          state_d = S_RESP;
          rdata_d = we_q ? 32'd0 : TIMEOUT_DATA;
          err_d   = 1'b1;
          if (tcount_q != 16'hFFFF) begin
            tcount_d = tcount_q + 16'd1;
          end
        end
      end
      S_RESP: begin
        state_d    = S_IDLE;
        last_gnt_d = gnt_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs: combinational accept in IDLE, registered target drive and response.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if ((state_q == S_IDLE) && any_req) begin
      req_ready[gnt_idx] = 1'b1;
    end
    if (state_q == S_RESP) begin
      rsp_valid[gnt_q] = 1'b1;
    end
    reg_valid     = (state_q == S_ISSUE);
    reg_we        = we_q;
    reg_addr      = addr_q;
    reg_wdata     = wdata_q;
    rsp_rdata     = rdata_q;
    rsp_err       = err_q;
    timeout_count = tcount_q;
  end

endmodule

// File: doc/cl_reg_access_arbiter.md
Name: cl_reg_access_arbiter

Overview:
- Shares one single-beat register-access port, such as the hello-world/VLED register core, among NREQ requesters.
- Typical requesters: the OCL AXI-L slave decode and an internal or debug sequencer.
- Grants round-robin and keeps exactly one transaction outstanding.
- Guards the target with a completion timeout, so a hung target cannot stall the host.

Parameters:
- NREQ, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 64, cycles in ISSUE before forced completion; 0 disables the timeout.
- TIMEOUT_DATA, 32'hDEAD_BEEF, read data returned on timeout.

Ports:
- clk_main_a0  in  1  main clock.
- rst_main_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-requester request; held with its fields until req_ready.
- req_we  in  NREQ  1 = write, 0 = read.
- req_addr  in  32*NREQ  flattened; requester i uses [32i+31:32i].
- req_wdata  in  32*NREQ  flattened write data, same packing as req_addr.
- req_ready  out  NREQ  one-hot accept pulse.
- rsp_valid  out  NREQ  one-hot completion pulse.
- rsp_rdata  out  32  read data, valid with rsp_valid.
- rsp_err  out  1  completion was a timeout, valid with rsp_valid.
- reg_valid  out  1  request to target.
- reg_we  out  1  write enable to target.
- reg_addr  out  32  address to target.
- reg_wdata  out  32  write data to target.
- reg_ready  in  1  target completion strobe.
- reg_rdata  in  32  target read data, sampled when reg_ready=1.
- timeout_count  out  16  saturating count of timeouts.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Round-robin pointer last_gnt = NREQ-1, so requester 0 wins first after reset.
  - timeout_count 0.
- Reset mid-transaction: the transaction is abandoned and no rsp_valid is generated.
- FSM states IDLE, ISSUE, RESP.
- IDLE, grant selection:
  - If any req_valid is set, grant g is the first set bit scanning last_gnt+1, last_gnt+2, ... modulo NREQ.
  - req_ready[g]=1 combinationally in that cycle.
  - On the clock edge, capture req_we/addr/wdata[g] and g, then go to ISSUE.
- IDLE, no request: stay in IDLE with req_ready=0.
- ISSUE, driving the target:
  - reg_valid=1, with reg_we/addr/wdata held stable from the registered copy.
  - The timeout counter increments each cycle.
- ISSUE, normal completion:
  - reg_ready=1 → capture reg_rdata for a read (0 for a write).
  - rsp_err stays 0; go to RESP.
  - reg_valid deasserts in the following cycle.
- ISSUE, timeout:
  - The counter reaches TIMEOUT_CYCLES without reg_ready → capture TIMEOUT_DATA for a read (0 for a write).
  - Set rsp_err=1 and increment timeout_count, saturating at 16'hFFFF; go to RESP.
  - A reg_ready arriving in the same cycle as the timeout takes priority: normal completion, no error.
- RESP:
  - rsp_valid[g]=1 for exactly one cycle, with rsp_rdata and rsp_err valid.
  - last_gnt <= g; go to IDLE.
  - rsp_rdata and rsp_err hold until the next completion.
- Latency: req_valid at cycle T → req_ready at T → reg_valid at T+1 → reg_ready at T+1 at the earliest → rsp_valid at T+2.
- Throughput: at most one transaction per 3 cycles.
- Requester rules:
  - A requester keeps req_valid low after req_ready until it has seen its rsp_valid.
  - A req_valid seen while state ≠ IDLE is not acknowledged and waits.
- Timeout counter: width $clog2(TIMEOUT_CYCLES+1), cleared on every entry to ISSUE.
- reg_ready seen outside ISSUE is ignored.

Test Plan:
- Reset then a single read: r0 reads 0x0500 and the target returns 0x1234_5678 one cycle after reg_valid → req_ready[0] at T, rsp_valid=2'b01 at T+3, rsp_rdata=0x1234_5678, rsp_err=0.
- Simultaneous requests, both held continuously:
  - Expected grant order 0, 1, 0, 1.
  - Each requester re-raises req_valid after its rsp_valid.
- Write path: r1 writes 0x0000_00AA to 0x0504 → reg_we=1, reg_addr=0x0504 and reg_wdata=0xAA stable until reg_ready; rsp_rdata=0.
- Timeout: TIMEOUT_CYCLES=8 and the target never readies → rsp_valid exactly 8 cycles after ISSUE entry, rsp_rdata=0xDEAD_BEEF, rsp_err=1, timeout_count=1; the next read completes normally with rsp_err=0.
- Timeout race: reg_ready in the same cycle the counter hits the limit → normal completion with target data, rsp_err=0, timeout_count unchanged.
- Reset mid-ISSUE: assert rst_main_n=0 for 2 cycles during reg_valid → reg_valid drops immediately (asynchronous), no rsp_valid, and the next arbitration grants r0 first.
